mem_read: RTL and testbench

//  Sequential reader for on-chip RAM; the counterpart of the write sequencer on the same

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/rd_buf_fifo.sv | 55 +++++
 rtl/mem_read.sv | 149 ++++++++++++++
 tb/tb_mem_read.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the on-chip RAM read/write sequencers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } mem_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/rd_buf_fifo.sv
// Small synchronous FIFO holding RAM read returns until the consumer takes them.
module rd_buf_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [DATA_W-1:0]              head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // An empty buffer presents zero rather than a stale word.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mem_read.sv
// Sequential RAM reader: issues a burst of reads and streams the returned bytes
// out over valid/ready, with credit-based issue so the return buffer never overflows.
module mem_read
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              stop_read,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_en,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = RD_LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = CW + 1;
    localparam int LW    = ADDR_W + 1;

    if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
        $error("mem_read: RD_LAT must be 1 or 2");
    end

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [LW-1:0]     len_r;
    logic [LW-1:0]     issue_cnt;
    logic [LW-1:0]     accept_cnt;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] vpipe_nxt;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              pop;
    logic              push;
    logic              flush;
    logic              start_ok;

    assign start_ok  = (state == IDLE) && start && !stop_read;
    assign flush     = stop_read && ((state == ISSUE) || (state == DRAIN));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = vpipe[RD_LAT-1] && !flush;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
    end

    // A read may issue only if the word it returns is guaranteed a buffer slot.
    assign rd_en = (state == ISSUE) && !stop_read && (issue_cnt != len_r) &&
                   ((SW'(inflight) + SW'(fifo_count)) < (SW'(DEPTH) + SW'(pop)));

    always_comb begin
        vpipe_nxt    = vpipe << 1;
        vpipe_nxt[0] = rd_en;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = (length == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (stop_read) begin
                    state_nxt = DONE;
                end else if (rd_en && ((issue_cnt + LW'(1)) == len_r)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (stop_read) begin
                    state_nxt = DONE;
                end else if (pop && ((accept_cnt + LW'(1)) == len_r)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_address <= '0;
            len_r      <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            vpipe      <= '0;
        end else begin
            if (start_ok) begin
                rd_address <= base_addr;
                len_r      <= length;
                issue_cnt  <= '0;
                accept_cnt <= '0;
            end else begin
                if (rd_en) begin
                    rd_address <= rd_address + ADDR_W'(1);
                    issue_cnt  <= issue_cnt + LW'(1);
                end
                if (pop) begin
                    accept_cnt <= accept_cnt + LW'(1);
                end
            end
            // Clearing the tags on abort makes late RAM returns fall on the floor.
            vpipe <= flush ? '0 : vpipe_nxt;
        end
    end

    rd_buf_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (q),
        .pop       (pop),
        .flush     (flush),
        .count     (fifo_count),
        .head      (out_data)
    );

endmodule

// File: tb/tb_mem_read.sv
// Drives RD_LAT=1 and RD_LAT=2 readers with identical bursts and checks them
// against a transaction-level model of the RAM contents and handshake rules.
module tb_mem_read;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop_read;
    logic       out_ready;
    logic [7:0] base_addr;
    logic [8:0] length;

    logic [7:0] addr_l1, addr_l2, q_l1, q_l2, q_l2_stage, data_l1, data_l2;
    logic       rden_l1, rden_l2, valid_l1, valid_l2, busy_l1, busy_l2, done_l1, done_l2;

    logic [7:0] m_addr [2];
    logic [7:0] m_data [2];
    logic       m_rden [2];
    logic       m_valid[2];
    logic       m_busy [2];
    logic       m_done [2];

    logic [7:0] ram [256];

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [7:0] recv    [2][256];
    logic [7:0] addr_log[2][256];
    int recv_n[2], addr_n[2], first_valid[2], last_acc[2], done_cyc[2];
    int done_pulses[2], busy_cycles[2], credit_bad[2], stall_bad[2];
    bit         prev_stall[2];
    logic [7:0] prev_data[2];

    always #5 clk = ~clk;

    mem_read #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .stop_read(stop_read), .rd_address(addr_l1), .rd_en(rden_l1), .q(q_l1),
        .out_data(data_l1), .out_valid(valid_l1), .out_ready(out_ready),
        .busy(busy_l1), .done(done_l1)
    );

    mem_read #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .stop_read(stop_read), .rd_address(addr_l2), .rd_en(rden_l2), .q(q_l2),
        .out_data(data_l2), .out_valid(valid_l2), .out_ready(out_ready),
        .busy(busy_l2), .done(done_l2)
    );

    // RAM models with one- and two-cycle read latency.
    always @(posedge clk) begin
        q_l1       <= ram[addr_l1];
        q_l2_stage <= ram[addr_l2];
        q_l2       <= q_l2_stage;
    end

    always_comb begin
        m_addr[0] = addr_l1;  m_addr[1] = addr_l2;
        m_data[0] = data_l1;  m_data[1] = data_l2;
        m_rden[0] = rden_l1;  m_rden[1] = rden_l2;
        m_valid[0] = valid_l1; m_valid[1] = valid_l2;
        m_busy[0] = busy_l1;  m_busy[1] = busy_l2;
        m_done[0] = done_l1;  m_done[1] = done_l2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_val(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s_addr_lat%0d", tag, d + 1), 32'(m_addr[d]), 0);
            checkOutput($sformatf("%s_rden_lat%0d", tag, d + 1), 32'(m_rden[d]), 0);
            checkOutput($sformatf("%s_valid_lat%0d", tag, d + 1), 32'(m_valid[d]), 0);
            checkOutput($sformatf("%s_data_lat%0d", tag, d + 1), 32'(m_data[d]), 0);
            checkOutput($sformatf("%s_busy_lat%0d", tag, d + 1), 32'(m_busy[d]), 0);
            checkOutput($sformatf("%s_done_lat%0d", tag, d + 1), 32'(m_done[d]), 0);
        end
    endtask

    // One burst on both readers; entered and left at posedge+1.
    task automatic applyStimulus(input string tag, input logic [7:0] base, input logic [8:0] len,
                                 input int ready_mode, input int stop_after);
        int  k;
        int  stop_cyc;
        bit  finished;
        for (int d = 0; d < 2; d++) begin
            recv_n[d] = 0; addr_n[d] = 0; first_valid[d] = -1; last_acc[d] = -1;
            done_cyc[d] = -1; done_pulses[d] = 0; busy_cycles[d] = 0;
            credit_bad[d] = 0; stall_bad[d] = 0; prev_stall[d] = 0; prev_data[d] = '0;
        end
        stop_cyc  = -1;
        finished  = 0;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        stop_read = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        k         = 1;
        out_ready = ready_val(ready_mode, k);
        while (!finished && k <= 600) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (m_rden[d]) begin
                    if (addr_n[d] < 256) addr_log[d][addr_n[d]] = m_addr[d];
                    addr_n[d]++;
                    if (addr_n[d] - (recv_n[d] + int'(m_valid[d] && out_ready)) > d + 2)
                        credit_bad[d]++;
                end
                if (m_valid[d] && first_valid[d] < 0) first_valid[d] = k;
                if (prev_stall[d] && k != stop_cyc + 1 &&
                    !(m_valid[d] && m_data[d] == prev_data[d]))
                    stall_bad[d]++;
                if (m_valid[d] && out_ready) begin
                    if (recv_n[d] < 256) recv[d][recv_n[d]] = m_data[d];
                    recv_n[d]++;
                    last_acc[d] = k;
                end
                prev_stall[d] = m_valid[d] && !out_ready;
                prev_data[d]  = m_data[d];
                if (m_done[d]) begin
                    done_pulses[d]++;
                    if (done_cyc[d] < 0) done_cyc[d] = k;
                end
                if (m_busy[d]) busy_cycles[d]++;
                if (stop_cyc >= 0 && k == stop_cyc + 1) begin
                    checkOutput($sformatf("%s_stop_valid_lat%0d", tag, d + 1), 32'(m_valid[d]), 0);
                    checkOutput($sformatf("%s_stop_done_lat%0d", tag, d + 1), 32'(m_done[d]), 1);
                end
            end
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0 && k > done_cyc[0] && k > done_cyc[1])
                finished = 1;
            @(posedge clk);
            #1;
            k++;
            stop_read = 1'b0;
            out_ready = ready_val(ready_mode, k);
            if (!finished && stop_after >= 0 && stop_cyc < 0 && recv_n[0] == stop_after) begin
                stop_read = 1'b1;
                out_ready = 1'b0;
                stop_cyc  = k;
            end
        end
        stop_read = 1'b0;
        checkOutput({tag, "_terminates"}, 32'(finished), 1);

        for (int d = 0; d < 2; d++) begin
            string t;
            t = $sformatf("%s_lat%0d", tag, d + 1);
            if (stop_after >= 0) begin
                checkOutput({t, "_stop_recv_bound"}, 32'(recv_n[d] <= stop_after), 1);
                checkOutput({t, "_stop_issue_bound"}, 32'(addr_n[d] <= int'(len)), 1);
                checkOutput({t, "_stop_done_cycle"}, 32'(done_cyc[d]), 32'(stop_cyc + 1));
            end else begin
                checkOutput({t, "_recv_count"}, 32'(recv_n[d]), 32'(len));
                checkOutput({t, "_issue_count"}, 32'(addr_n[d]), 32'(len));
                if (len == 0)
                    checkOutput({t, "_empty_done_cycle"}, 32'(done_cyc[d]), 1);
                else
                    checkOutput({t, "_done_after_last"}, 32'(done_cyc[d]), 32'(last_acc[d] + 1));
                if (ready_mode == 0 && len != 0) begin
                    checkOutput({t, "_first_valid"}, 32'(first_valid[d]), 32'(d + 3));
                    checkOutput({t, "_no_bubbles"}, 32'(last_acc[d] - first_valid[d]), 32'(int'(len) - 1));
                end
            end
            for (int i = 0; i < recv_n[d] && i < 256; i++)
                checkOutput($sformatf("%s_byte%0d", t, i), 32'(recv[d][i]), 32'(ram[8'(base + i)]));
            for (int i = 0; i < addr_n[d] && i < 256; i++)
                checkOutput($sformatf("%s_addr%0d", t, i), 32'(addr_log[d][i]), 32'(8'(base + i)));
            checkOutput({t, "_credit"}, 32'(credit_bad[d]), 0);
            checkOutput({t, "_stall_hold"}, 32'(stall_bad[d]), 0);
            checkOutput({t, "_done_pulses"}, 32'(done_pulses[d]), 1);
            checkOutput({t, "_busy_span"}, 32'(busy_cycles[d]), 32'(done_cyc[d]));
        end
    endtask

    task automatic load_ram_pattern();
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        stop_read = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        length    = '0;
        load_ram_pattern();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic burst");
        applyStimulus("basic", 8'h10, 9'd4, 0, -1);
        $display("[TB] address wrap");
        applyStimulus("wrap", 8'hFE, 9'd4, 0, -1);
        $display("[TB] back-pressure");
        applyStimulus("stall", 8'h20, 9'd5, 1, -1);
        $display("[TB] zero length");
        applyStimulus("zero", 8'h33, 9'd0, 0, -1);

        start     = 1'b1;
        stop_read = 1'b1;
        base_addr = 8'h50;
        length    = 9'd3;
        @(posedge clk);
        #1;
        start     = 1'b0;
        stop_read = 1'b0;
        @(negedge clk);
        checkOutput("start_stop_idle_lat1", 32'(m_busy[0]), 0);
        checkOutput("start_stop_idle_lat2", 32'(m_busy[1]), 0);
        @(posedge clk);
        #1;

        $display("[TB] abort and restart");
        applyStimulus("abort", 8'h40, 9'd10, 0, 2);
        applyStimulus("after_abort", 8'h00, 9'd2, 0, -1);

        $display("[TB] randomized bursts");
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        for (int n = 0; n < 6; n++)
            applyStimulus($sformatf("rand%0d", n), 8'($urandom_range(0, 255)),
                          9'($urandom_range(1, 24)), 2, -1);
        applyStimulus("full_span", 8'($urandom_range(0, 255)), 9'd256, 0, -1);

        $display("[TB] async reset mid-burst");
        load_ram_pattern();
        start     = 1'b1;
        base_addr = 8'h10;
        length    = 9'd10;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("rerun", 8'h10, 9'd4, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
